// File: rtl/scmp_microcode_pak.sv
// Shared microcode types for the SC/MP core: entry labels, decode tag and the opcode decode table.
package scmp_microcode_pak;

    typedef enum logic [4:0] {
        PcFetch, PcHalt, PcDly, PcXae, PcSt, PcDad, PcLd, PcDae, PcLde, PcIld, PcDld,
        PcJmp, PcXpal, PcXpah, PcXppc, PcCl, PcIe, PcCsa, PcCas, PcNop, PcSio
    } NEXTPC_t;

    typedef struct packed {
        NEXTPC_t pc;
        logic    dly;
    } opdec_tag_t;

    typedef struct packed {
        logic [7:0] data;
        opdec_tag_t tag;
    } opq_entry_t;

    // First match wins; overlapping ranges rely on this ordering.
    function automatic opdec_tag_t opdec_decode(input logic [7:0] op);
        opdec_tag_t t;
        t.pc  = PcFetch;
        t.dly = 1'b0;
        if (op == 8'h00)                                t.pc = PcHalt;
        else if (op == 8'h8F) begin
            t.pc  = PcDly;
            t.dly = 1'b1;
        end
        else if (op == 8'h01)                           t.pc = PcXae;
        else if (op[7:3] == 5'b11001 && op != 8'hCC)    t.pc = PcSt;
        else if (op[7:3] == 5'b11101)                   t.pc = PcDad;
        else if (op[7:6] == 2'b11)                      t.pc = PcLd;
        else if (op == 8'h68)                           t.pc = PcDae;
        else if (op[7:6] == 2'b01 && op[2:0] == 3'b000) t.pc = PcLde;
        else if (op[7:2] == 6'b101010)                  t.pc = PcIld;
        else if (op[7:2] == 6'b101110)                  t.pc = PcDld;
        else if (op[7:4] == 4'h9)                       t.pc = PcJmp;
        else if (op[7:2] == 6'b001100)                  t.pc = PcXpal;
        else if (op[7:2] == 6'b001101)                  t.pc = PcXpah;
        else if (op[7:2] == 6'b001111)                  t.pc = PcXppc;
        else if (op[7:1] == 7'b0000001)                 t.pc = PcCl;
        else if (op[7:1] == 7'b0000010)                 t.pc = PcIe;
        else if (op == 8'h06)                           t.pc = PcCsa;
        else if (op == 8'h07)                           t.pc = PcCas;
        else if (op == 8'h08)                           t.pc = PcNop;
        else if (op == 8'h19)                           t.pc = PcSio;
        return t;
    endfunction

endpackage

// File: rtl/scmp_opdec_core.sv
// Combinational opcode decoder on the prefetch queue write path.
module scmp_opdec_core
    import scmp_microcode_pak::*;
(
    input  logic [7:0] op_i,
    output opdec_tag_t tag_o
);

    assign tag_o = opdec_decode(op_i);

endmodule

// File: rtl/scmp_opdec_queue.sv
// Prefetch byte queue with decode-at-write, presenting whole instructions to the sequencer.
// Optional instruction counter port/logic enabled by defining SCMP_OPDEC_STATS_EN.
module scmp_opdec_queue
    import scmp_microcode_pak::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_byte,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_op,
    output logic [7:0]       out_disp,
    output logic             out_len2,
    output NEXTPC_t          out_pc,
    output logic             out_dly,
    output logic [CNT_W-1:0] count
`ifdef SCMP_OPDEC_STATS_EN
    ,
    output logic [15:0]      icount
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    opq_entry_t       mem_q [DEPTH];
    opq_entry_t       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] rd_ptr_p1;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] pop_n;
    logic             exp_disp_q, exp_disp_d;
    opdec_tag_t       in_tag;
    logic             push, pop, len2;

    scmp_opdec_core u_core (
        .op_i  (in_byte),
        .tag_o (in_tag)
    );

    assign rd_ptr_p1 = rd_ptr_q + 1'b1;
    assign len2      = mem_q[rd_ptr_q].data[7];

    assign in_ready  = count_q < CNT_W'(DEPTH);
    // A two-byte op is only presented once its displacement has landed.
    assign out_valid = (count_q != '0 && !len2) || count_q >= CNT_W'(2);
    assign out_op    = mem_q[rd_ptr_q].data;
    assign out_disp  = len2 ? mem_q[rd_ptr_p1].data : 8'h00;
    assign out_len2  = len2;
    assign out_pc    = mem_q[rd_ptr_q].tag.pc;
    assign out_dly   = mem_q[rd_ptr_q].tag.dly;
    assign count     = count_q;

    assign push  = in_valid && in_ready;
    assign pop   = out_valid && out_ready;
    assign pop_n = pop ? (len2 ? CNT_W'(2) : CNT_W'(1)) : '0;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        exp_disp_d = exp_disp_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            exp_disp_d = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{data: in_byte, tag: in_tag};
                wr_ptr_d        = wr_ptr_q + 1'b1;
                // Operand bytes never set the flag, keeping opcode alignment.
                exp_disp_d      = exp_disp_q ? 1'b0 : in_byte[7];
            end
            if (pop) begin
                rd_ptr_d = len2 ? rd_ptr_q + PTR_W'(2) : rd_ptr_p1;
            end
            count_d = count_q + CNT_W'(push) - pop_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            exp_disp_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            exp_disp_q <= exp_disp_d;
        end
    end

`ifdef SCMP_OPDEC_STATS_EN
    logic [15:0] icount_q, icount_d;

    always_comb begin
        icount_d = icount_q;
        if (pop) begin
            icount_d = icount_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            icount_q <= '0;
        end else begin
            icount_q <= icount_d;
        end
    end

    assign icount = icount_q;
`endif

endmodule

// File: tb/tb_scmp_opdec_queue.sv
// Self-checking bench for scmp_opdec_queue against a byte-queue reference model.
module tb_scmp_opdec_queue;
    import scmp_microcode_pak::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_byte = 8'h00;
    logic             out_ready = 1'b0;
    logic             in_ready, out_valid, out_len2, out_dly;
    logic [7:0]       out_op, out_disp;
    NEXTPC_t          out_pc;
    logic [CNT_W-1:0] count;
`ifdef SCMP_OPDEC_STATS_EN
    logic [15:0]      icount;
`endif

    int n_vec = 0;
    int n_err = 0;

    bit [7:0] mq[$];
    int       m_icnt = 0;

    scmp_opdec_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_byte   (in_byte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op    (out_op),
        .out_disp  (out_disp),
        .out_len2  (out_len2),
        .out_pc    (out_pc),
        .out_dly   (out_dly),
        .count     (count)
`ifdef SCMP_OPDEC_STATS_EN
        ,
        .icount    (icount)
`endif
    );

    always #5 clk = ~clk;

    function automatic NEXTPC_t ref_pc(input bit [7:0] b);
        NEXTPC_t p;
        case (b) inside
            8'h00:                     p = PcHalt;
            8'h8F:                     p = PcDly;
            8'h01:                     p = PcXae;
            8'hCC:                     p = PcLd;
            [8'hC8:8'hCF]:             p = PcSt;
            [8'hE8:8'hEF]:             p = PcDad;
            [8'hC0:8'hFF]:             p = PcLd;
            8'h68:                     p = PcDae;
            8'h40, 8'h48, 8'h50, 8'h58,
            8'h60, 8'h70, 8'h78:       p = PcLde;
            [8'hA8:8'hAB]:             p = PcIld;
            [8'hB8:8'hBB]:             p = PcDld;
            [8'h90:8'h9F]:             p = PcJmp;
            [8'h30:8'h33]:             p = PcXpal;
            [8'h34:8'h37]:             p = PcXpah;
            [8'h3C:8'h3F]:             p = PcXppc;
            [8'h02:8'h03]:             p = PcCl;
            [8'h04:8'h05]:             p = PcIe;
            8'h06:                     p = PcCsa;
            8'h07:                     p = PcCas;
            8'h08:                     p = PcNop;
            8'h19:                     p = PcSio;
            default:                   p = PcFetch;
        endcase
        return p;
    endfunction

    function automatic bit m_valid();
        return (mq.size() >= 1 && !mq[0][7]) || mq.size() >= 2;
    endfunction

    // One clock: advance DUT and model together, sample #1 after the edge.
    task automatic tick();
        bit       do_push, do_pop, two;
        bit [7:0] b;
        do_push = in_valid && (mq.size() < DEPTH) && !flush;
        do_pop  = m_valid() && out_ready;
        b       = in_byte;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            mq.delete();
            m_icnt = 0;
        end else begin
            if (do_pop) m_icnt++;
            if (flush) begin
                mq.delete();
            end else begin
                if (do_pop) begin
                    two = mq[0][7];
                    void'(mq.pop_front());
                    if (two) void'(mq.pop_front());
                end
                if (do_push) mq.push_back(b);
            end
        end
    endtask

    task automatic push_byte(input bit [7:0] b);
        in_valid  = 1'b1;
        in_byte   = b;
        out_ready = 1'b0;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        in_valid = 1'b1;
        in_byte  = 8'h08;
        do_reset();
        in_valid = 1'b0;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== 3'd0) begin
            n_err++;
            $display("FAIL reset: in_ready=%b out_valid=%b count=%0d, need 1 0 0",
                     in_ready, out_valid, count);
        end
`ifdef SCMP_OPDEC_STATS_EN
        n_vec++;
        if (icount !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_icount: got %h need 0000", icount);
        end
`endif
    endtask

    task automatic test_basic();
        push_byte(8'h08);
        n_vec++;
        if (out_valid !== 1'b1 || out_pc !== PcNop) begin
            n_err++;
            $display("FAIL basic_nop: valid=%b pc=%s, need 1 PcNop", out_valid, out_pc.name());
        end
        push_byte(8'h01);
        n_vec++;
        if (count !== 3'd2) begin
            n_err++;
            $display("FAIL basic_count2: got %0d need 2", count);
        end
        pop_one();
        n_vec++;
        if (out_valid !== 1'b1 || out_pc !== PcXae || out_len2 !== 1'b0 || out_disp !== 8'h00) begin
            n_err++;
            $display("FAIL basic_xae: valid=%b pc=%s len2=%b disp=%h, need 1 PcXae 0 00",
                     out_valid, out_pc.name(), out_len2, out_disp);
        end
        pop_one();
        n_vec++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_empty: count=%0d valid=%b, need 0 0", count, out_valid);
        end
    endtask

    task automatic test_two_byte();
        push_byte(8'hC4);
        n_vec++;
        if (out_valid !== 1'b0 || count !== 3'd1) begin
            n_err++;
            $display("FAIL two_byte_wait: valid=%b count=%0d, need 0 1", out_valid, count);
        end
        push_byte(8'h55);
        n_vec++;
        if (out_valid !== 1'b1 || out_op !== 8'hC4 || out_disp !== 8'h55 || out_pc !== PcLd ||
            out_len2 !== 1'b1) begin
            n_err++;
            $display("FAIL two_byte_head: valid=%b op=%h disp=%h pc=%s len2=%b, need 1 C4 55 PcLd 1",
                     out_valid, out_op, out_disp, out_pc.name(), out_len2);
        end
        pop_one();
        n_vec++;
        if (count !== 3'd0) begin
            n_err++;
            $display("FAIL two_byte_pop: count=%0d need 0", count);
        end
    endtask

    task automatic test_decode();
        bit [7:0] ops[7]  = '{8'hCC, 8'hCF, 8'h8F, 8'h68, 8'h48, 8'h3B, 8'h00};
        NEXTPC_t  pcs[7]  = '{PcLd, PcSt, PcDly, PcDae, PcLde, PcFetch, PcHalt};
        bit [7:0] op;
        NEXTPC_t  exp_pc;
        for (int i = 0; i < 7 + 40; i++) begin
            op     = (i < 7) ? ops[i] : 8'($urandom_range(0, 255));
            exp_pc = (i < 7) ? pcs[i] : ref_pc(op);
            push_byte(op);
            if (op[7]) push_byte(8'h5A);
            n_vec++;
            if (out_valid !== 1'b1 || out_op !== op || out_pc !== exp_pc ||
                out_dly !== (op == 8'h8F)) begin
                n_err++;
                $display("FAIL decode_%h: valid=%b op=%h pc=%s dly=%b, need 1 %h %s %b",
                         op, out_valid, out_op, out_pc.name(), out_dly, op, exp_pc.name(),
                         op == 8'h8F);
            end
            pop_one();
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) push_byte(8'h08);
        n_vec++;
        if (in_ready !== 1'b0 || count !== 3'd4) begin
            n_err++;
            $display("FAIL full: in_ready=%b count=%0d, need 0 4", in_ready, count);
        end
        in_valid  = 1'b1;
        in_byte   = 8'h01;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        n_vec++;
        if (count !== 3'd3 || in_ready !== 1'b1 || out_op !== 8'h08) begin
            n_err++;
            $display("FAIL full_pushpop: count=%0d in_ready=%b op=%h, need 3 1 08",
                     count, in_ready, out_op);
        end
        for (int i = 0; i < 3; i++) tick();
        out_ready = 1'b0;
        n_vec++;
        if (count !== 3'd0) begin
            n_err++;
            $display("FAIL full_drain: count=%0d need 0", count);
        end
    endtask

    task automatic test_wrap();
        bit [7:0] pat[4] = '{8'hC4, 8'h55, 8'h08, 8'h01};
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) push_byte(pat[(i + r) % 4]);
            for (int k = 0; k < 4 && mq.size() > 0; k++) begin
                n_vec++;
                if (out_valid !== m_valid() || (m_valid() && out_op !== mq[0])) begin
                    n_err++;
                    $display("FAIL wrap_r%0d: valid=%b op=%h, need %b %h",
                             r, out_valid, out_op, m_valid(), mq[0]);
                end
                if (!m_valid()) begin
                    flush = 1'b1;
                    tick();
                    flush = 1'b0;
                end else begin
                    pop_one();
                end
            end
            n_vec++;
            if (count !== 3'd0) begin
                n_err++;
                $display("FAIL wrap_empty_r%0d: count=%0d need 0", r, count);
            end
        end
    endtask

    task automatic test_flush();
        push_byte(8'h08);
        push_byte(8'h01);
        push_byte(8'hC4);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_byte  = 8'h77;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_vec++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_empty: count=%0d valid=%b, need 0 0", count, out_valid);
        end
        push_byte(8'h90);
        n_vec++;
        if (out_valid !== 1'b0 || out_pc !== PcJmp || out_len2 !== 1'b1) begin
            n_err++;
            $display("FAIL flush_realign: valid=%b pc=%s len2=%b, need 0 PcJmp 1",
                     out_valid, out_pc.name(), out_len2);
        end
        push_byte(8'h12);
        n_vec++;
        if (out_valid !== 1'b1 || out_op !== 8'h90 || out_disp !== 8'h12) begin
            n_err++;
            $display("FAIL flush_jmp: valid=%b op=%h disp=%h, need 1 90 12",
                     out_valid, out_op, out_disp);
        end
        pop_one();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_byte   = 8'($urandom_range(0, 255));
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            rst_n     = (c != 200);
            tick();
            n_vec++;
            if (count !== CNT_W'(mq.size()) || in_ready !== (mq.size() < DEPTH) ||
                out_valid !== m_valid()) begin
                n_err++;
                $display("FAIL random_c%0d: count=%0d in_ready=%b valid=%b, need %0d %b %b",
                         c, count, in_ready, out_valid, mq.size(), mq.size() < DEPTH, m_valid());
            end
            if (m_valid()) begin
                n_vec++;
                if (out_op !== mq[0] || out_len2 !== mq[0][7] ||
                    out_disp !== (mq[0][7] ? mq[1] : 8'h00) || out_pc !== ref_pc(mq[0]) ||
                    out_dly !== (mq[0] == 8'h8F)) begin
                    n_err++;
                    $display("FAIL random_head_c%0d: op=%h disp=%h len2=%b pc=%s, need %h %h %b %s",
                             c, out_op, out_disp, out_len2, out_pc.name(), mq[0],
                             mq[0][7] ? mq[1] : 8'h00, mq[0][7], ref_pc(mq[0]).name());
                end
            end
`ifdef SCMP_OPDEC_STATS_EN
            n_vec++;
            if (icount !== 16'(m_icnt)) begin
                n_err++;
                $display("FAIL random_icount_c%0d: got %h need %h", c, icount, 16'(m_icnt));
            end
`endif
        end
        rst_n     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

`ifdef SCMP_OPDEC_STATS_EN
    task automatic test_stats();
        do_reset();
        in_valid  = 1'b1;
        in_byte   = 8'h08;
        out_ready = 1'b1;
        for (int i = 0; i < 70000 && m_icnt < 65537; i++) tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_vec++;
        if (m_icnt != 65537 || icount !== 16'h0001) begin
            n_err++;
            $display("FAIL stats_wrap: pops=%0d icount=%h, need 65537 0001", m_icnt, icount);
        end
        in_valid = 1'b1;
        rst_n    = 1'b0;
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        n_vec++;
        if (icount !== 16'h0000 || count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL stats_reset: icount=%h count=%0d valid=%b in_ready=%b, need 0000 0 0 1",
                     icount, count, out_valid, in_ready);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_two_byte();
        test_decode();
        test_full();
        test_wrap();
        test_flush();
        test_random();
`ifdef SCMP_OPDEC_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
